// File: rtl/fpnew_f2fcast_vec.sv
// fpnew_f2fcast_vec -- multi-cycle packed float-to-float cast, one lane per cycle on a shared datapath.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

package fpnew_pkg;
   typedef enum logic [2:0] {FP32 = 3'd0, FP64 = 3'd1, FP16 = 3'd2, FP8 = 3'd3, FP16ALT = 3'd4} fp_format_e;
   typedef enum logic [2:0] {RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011,
                             RMM = 3'b100, ROD = 3'b101, DYN = 3'b111} roundmode_e;
   typedef struct packed {
      logic NV;
      logic DZ;
      logic OF;
      logic UF;
      logic NX;
   } status_t;

   function automatic int unsigned exp_bits(fp_format_e f);
      case (f)
         FP64:    return 11;
         FP16:    return 5;
         FP8:     return 5;
         default: return 8;
      endcase
   endfunction

   function automatic int unsigned man_bits(fp_format_e f);
      case (f)
         FP64:    return 52;
         FP16:    return 10;
         FP8:     return 2;
         FP16ALT: return 7;
         default: return 23;
      endcase
   endfunction

   function automatic int unsigned fp_width(fp_format_e f);
      return 1 + exp_bits(f) + man_bits(f);
   endfunction
endpackage

module fpnew_f2fcast_vec #(
   parameter fpnew_pkg::fp_format_e SrcFpFormat = fpnew_pkg::FP32,
   parameter fpnew_pkg::fp_format_e DstFpFormat = fpnew_pkg::FP16,
   parameter int unsigned           NumLanes    = 4,
   parameter type                   TagType     = logic,
   localparam int unsigned SRC_WIDTH = fpnew_pkg::fp_width(SrcFpFormat),
   localparam int unsigned DST_WIDTH = fpnew_pkg::fp_width(DstFpFormat)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NumLanes*SRC_WIDTH-1:0] operands_i,
   input  logic [NumLanes-1:0]           lane_mask_i,
   input  fpnew_pkg::roundmode_e         rnd_mode_i,
   input  TagType                        tag_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic                          flush_i,
   output logic [NumLanes*DST_WIDTH-1:0] result_o,
   output fpnew_pkg::status_t            status_o,
   output TagType                        tag_o,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic                          busy_o
);
   localparam int SE       = int'(fpnew_pkg::exp_bits(SrcFpFormat));
   localparam int SM       = int'(fpnew_pkg::man_bits(SrcFpFormat));
   localparam int DE       = int'(fpnew_pkg::exp_bits(DstFpFormat));
   localparam int DM       = int'(fpnew_pkg::man_bits(DstFpFormat));
   localparam int DW       = DE + DM;
   localparam int SRC_BIAS = 2 ** (SE - 1) - 1;
   localparam int DST_BIAS = 2 ** (DE - 1) - 1;
   localparam int DST_EMAX = 2 ** DE - 1;
   localparam int P        = SM + 1;
   localparam int W        = P + DM + 2;
   localparam int CW       = (NumLanes > 1) ? $clog2(NumLanes) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, DONE = 2'd2} state_e;

   state_e                        state_q, state_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic [NumLanes*SRC_WIDTH-1:0] ops_q, ops_d;
   logic [NumLanes-1:0]           mask_q, mask_d;
   fpnew_pkg::roundmode_e         rnd_q, rnd_d;
   TagType                        tag_q, tag_d;
   logic [NumLanes*DST_WIDTH-1:0] result_q, result_d;
   fpnew_pkg::status_t            status_q, status_d;
   logic                          out_valid_q, out_valid_d;

   // Scalar datapath signals
   logic [SRC_WIDTH-1:0] lane_op;
   logic                 lane_en, s_sign, found;
   logic [SE-1:0]        s_exp;
   logic [SM-1:0]        s_man;
   logic                 is_zero, is_inf, is_nan, is_snan;
   logic [P-1:0]         sig, sig_norm;
   int                   lz, dexp, shamt;
   logic [W-1:0]         ext, lost_mask;
   logic [W-2:0]         shifted;
   logic [DM-1:0]        keep_man;
   logic                 lsb, rnd_bit, sticky, inexact, round_up, rne_up;
   logic                 of_pre, ovf, inf_out;
   logic [DE-1:0]        re;
   logic [DW-1:0]        sum, sum_rne;
   logic [DST_WIDTH-1:0] conv_res;
   fpnew_pkg::status_t   conv_flags;

   always_comb begin
      lane_op = ops_q[cnt_q*SRC_WIDTH +: SRC_WIDTH];
      lane_en = mask_q[cnt_q];
      {s_sign, s_exp, s_man} = lane_op;
      is_zero = (s_exp == '0) && (s_man == '0);
      is_inf  = (&s_exp) && (s_man == '0);
      is_nan  = (&s_exp) && (s_man != '0);
      is_snan = is_nan && !s_man[SM-1];
      sig     = {s_exp != '0, s_man};

      // Leading-zero count renormalizes source subnormals
      lz    = 0;
      found = 1'b0;
      for (int i = P - 1; i >= 0; i--) begin
         if (!found) begin
            if (sig[i]) found = 1'b1;
            else        lz = lz + 1;
         end
      end
      sig_norm = sig << lz;
      dexp = ((s_exp == '0) ? 1 : int'(s_exp)) - SRC_BIAS + DST_BIAS - lz;

      // Tiny results are shifted right into the subnormal range before rounding
      shamt = (dexp < 1) ? (1 - dexp) : 0;
      if (shamt > W) shamt = W;
      ext       = {sig_norm, {(DM + 2){1'b0}}};
      shifted   = (W - 1)'(ext >> shamt);
      lost_mask = ~({W{1'b1}} << shamt);
      keep_man  = shifted[W-2 -: DM];
      lsb       = shifted[W-1-DM];
      rnd_bit   = shifted[W-2-DM];
      sticky    = (|shifted[W-3-DM:0]) | (|(ext & lost_mask));
      inexact   = rnd_bit | sticky;
      rne_up    = rnd_bit & (sticky | lsb);

      case (rnd_q)
         fpnew_pkg::RNE: round_up = rne_up;
         fpnew_pkg::RDN: round_up = inexact & s_sign;
         fpnew_pkg::RUP: round_up = inexact & ~s_sign;
         fpnew_pkg::RMM: round_up = rnd_bit;
         default:        round_up = 1'b0;
      endcase

      // Overflow is judged on the nearest-rounded magnitude as well as the directed one
      of_pre  = dexp >= DST_EMAX;
      re      = ((dexp < 1) || of_pre) ? '0 : dexp[DE-1:0];
      sum     = {re, keep_man} + DW'(round_up);
      sum_rne = {re, keep_man} + DW'(rne_up);
      ovf     = of_pre | (&sum[DW-1:DM]) | (&sum_rne[DW-1:DM]);
      inf_out = (rnd_q == fpnew_pkg::RNE) || (rnd_q == fpnew_pkg::RMM) ||
                ((rnd_q == fpnew_pkg::RUP) && !s_sign) || ((rnd_q == fpnew_pkg::RDN) && s_sign);

      conv_res   = '0;
      conv_flags = '0;
      if (!lane_en) begin
         conv_res = '0;
      end else if (is_nan) begin
         conv_res      = {1'b0, {DE{1'b1}}, 1'b1, {(DM - 1){1'b0}}};
         conv_flags.NV = is_snan;
      end else if (is_inf) begin
         conv_res = {s_sign, {DE{1'b1}}, {DM{1'b0}}};
      end else if (is_zero) begin
         conv_res = {s_sign, {DW{1'b0}}};
      end else if (ovf) begin
         conv_res      = inf_out ? {s_sign, {DE{1'b1}}, {DM{1'b0}}}
                                 : {s_sign, {(DE - 1){1'b1}}, 1'b0, {DM{1'b1}}};
         conv_flags.OF = 1'b1;
         conv_flags.NX = 1'b1;
      end else begin
         conv_res      = {s_sign, sum};
         conv_flags.NX = inexact;
         conv_flags.UF = inexact && (sum[DW-1:DM] == '0);
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ops_d       = ops_q;
      mask_d      = mask_q;
      rnd_d       = rnd_q;
      tag_d       = tag_q;
      result_d    = result_q;
      status_d    = status_q;
      out_valid_d = out_valid_q;
      if (flush_i) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         status_d    = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid_i) begin
                  ops_d    = operands_i;
                  mask_d   = lane_mask_i;
                  rnd_d    = rnd_mode_i;
                  tag_d    = tag_i;
                  cnt_d    = '0;
                  status_d = '0;
                  state_d  = CONVERT;
               end
            end
            CONVERT: begin
               result_d[cnt_q*DST_WIDTH +: DST_WIDTH] = conv_res;
               status_d = status_q | conv_flags;
               if (cnt_q == CW'(NumLanes - 1)) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  state_d     = IDLE;
                  out_valid_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         ops_q       <= '0;
         mask_q      <= '0;
         rnd_q       <= fpnew_pkg::RNE;
         tag_q       <= '0;
         result_q    <= '0;
         status_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ops_q       <= ops_d;
         mask_q      <= mask_d;
         rnd_q       <= rnd_d;
         tag_q       <= tag_d;
         result_q    <= result_d;
         status_q    <= status_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign busy_o      = (state_q != IDLE);
   assign out_valid_o = out_valid_q;
   assign result_o    = result_q;
   assign status_o    = status_q;
   assign tag_o       = tag_q;
endmodule

`default_nettype wire

// File: tb/tb_fpnew_f2fcast_vec.sv
// tb_fpnew_f2fcast_vec -- directed scoreboard bench for the 4-lane FP32->FP16 cast.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_fpnew_f2fcast_vec;
   logic                  clk_i = 1'b0;
   logic                  rst_i;
   logic [127:0]          operands_i;
   logic [3:0]            lane_mask_i;
   fpnew_pkg::roundmode_e rnd_mode_i;
   logic                  tag_i;
   logic                  in_valid_i;
   logic                  in_ready_o;
   logic                  flush_i;
   logic [63:0]           result_o;
   fpnew_pkg::status_t    status_o;
   logic                  tag_o;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic                  busy_o;

   fpnew_f2fcast_vec dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .operands_i  (operands_i),
      .lane_mask_i (lane_mask_i),
      .rnd_mode_i  (rnd_mode_i),
      .tag_i       (tag_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .flush_i     (flush_i),
      .result_o    (result_o),
      .status_o    (status_o),
      .tag_o       (tag_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [63:0] res;
      logic [4:0]  st;
      logic        tg;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;
   int   fails  = 0;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", name, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Scoreboard consumer: compare at every delivered output
   always @(negedge clk_i) begin
      if (!rst_i && out_valid_o && out_ready_i) begin
         if (sb.size() == 0) begin
            chk("output_without_txn", 64'(sb.size()), 64'd1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", result_o, e.res);
            chk("status", 64'(status_o), 64'(e.st));
            chk("tag", 64'(tag_o), 64'(e.tg));
         end
      end
   end

   task automatic run_txn(input logic [127:0] ops, input logic [3:0] mask,
                          input fpnew_pkg::roundmode_e rm, input logic tg,
                          input logic [63:0] res, input logic [4:0] st, input bit push);
      int lat;
      operands_i  = ops;
      lane_mask_i = mask;
      rnd_mode_i  = rm;
      tag_i       = tg;
      in_valid_i  = 1'b1;
      tick();
      in_valid_i = 1'b0;
      if (push) sb.push_back('{res: res, st: st, tg: tg});
      chk("in_ready_convert", 64'(in_ready_o), 64'd0);
      chk("busy_convert", 64'(busy_o), 64'd1);
      lat = 0;
      while (!out_valid_o && lat < 20) begin
         tick();
         lat++;
      end
      chk("latency", 64'(lat), 64'd4);
   endtask

   task automatic finish_ok();
      tick();
      chk("idle_after_done", 64'(busy_o), 64'd0);
   endtask

   localparam logic [127:0] OPS_A = {32'h33000000, 32'h7F800001, 32'h477FF000, 32'h3F800000};
   localparam logic [127:0] OPS_M = {32'h7F800001, 32'h40000000, 32'h7F800001, 32'hBF800000};

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int seen;
      rst_i       = 1'b1;
      operands_i  = '0;
      lane_mask_i = '0;
      rnd_mode_i  = fpnew_pkg::RNE;
      tag_i       = 1'b0;
      in_valid_i  = 1'b0;
      flush_i     = 1'b0;
      out_ready_i = 1'b1;
      repeat (3) tick();
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_result", result_o, 64'd0);
      chk("rst_status", 64'(status_o), 64'd0);
      chk("rst_tag", 64'(tag_o), 64'd0);
      rst_i = 1'b0;
      tick();
      chk("post_rst_in_ready", 64'(in_ready_o), 64'd1);
      chk("post_rst_busy", 64'(busy_o), 64'd0);

      // Spec vectors: RNE, RTZ, partial mask
      run_txn(OPS_A, 4'b1111, fpnew_pkg::RNE, 1'b1, 64'h0000_7E00_7C00_3C00, 5'b10111, 1'b1);
      finish_ok();
      run_txn(OPS_A, 4'b1111, fpnew_pkg::RTZ, 1'b0, 64'h0000_7E00_7BFF_3C00, 5'b10111, 1'b1);
      finish_ok();
      run_txn(OPS_M, 4'b0101, fpnew_pkg::RNE, 1'b1, 64'h0000_4000_0000_BC00, 5'b00000, 1'b1);
      finish_ok();

      // Directed rounding: signed overflow, min normal/subnormal, ties, source subnormal
      run_txn({32'hFF800000, 32'h80000000, 32'hC77FF000, 32'h3F800001}, 4'b1111, fpnew_pkg::RUP,
              1'b0, 64'hFC00_8000_FBFF_3C01, 5'b00101, 1'b1);
      finish_ok();
      run_txn({32'h33800000, 32'h38800000, 32'h477FF000, 32'hC77FF000}, 4'b1111, fpnew_pkg::RDN,
              1'b1, 64'h0001_0400_7BFF_FC00, 5'b00101, 1'b1);
      finish_ok();
      run_txn({32'h00000001, 32'h7FC00000, 32'h3F801000, 32'h33000001}, 4'b1111, fpnew_pkg::RMM,
              1'b0, 64'h0000_7E00_3C01_0001, 5'b00011, 1'b1);
      finish_ok();

      // Backpressure in DONE
      out_ready_i = 1'b0;
      run_txn(OPS_A, 4'b1111, fpnew_pkg::RNE, 1'b0, 64'h0000_7E00_7C00_3C00, 5'b10111, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold_out_valid", 64'(out_valid_o), 64'd1);
         chk("hold_result", result_o, 64'h0000_7E00_7C00_3C00);
         chk("hold_in_ready", 64'(in_ready_o), 64'd0);
      end
      out_ready_i = 1'b1;
      tick();
      chk("release_busy", 64'(busy_o), 64'd0);
      chk("release_in_ready", 64'(in_ready_o), 64'd1);
      chk("release_out_valid", 64'(out_valid_o), 64'd0);

      // Flush on the second CONVERT cycle, after lane 0 has raised NV
      operands_i  = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F800001};
      lane_mask_i = 4'b1111;
      rnd_mode_i  = fpnew_pkg::RNE;
      in_valid_i  = 1'b1;
      tick();
      in_valid_i = 1'b0;
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("flush_busy", 64'(busy_o), 64'd0);
      chk("flush_out_valid", 64'(out_valid_o), 64'd0);
      chk("flush_status", 64'(status_o), 64'd0);
      seen = 0;
      repeat (6) begin
         tick();
         if (out_valid_o) seen++;
      end
      chk("flush_no_output", 64'(seen), 64'd0);

      // Flush beats a simultaneous input handshake
      in_valid_i = 1'b1;
      flush_i    = 1'b1;
      tick();
      in_valid_i = 1'b0;
      flush_i    = 1'b0;
      chk("flush_vs_accept_busy", 64'(busy_o), 64'd0);

      run_txn(OPS_M, 4'b0101, fpnew_pkg::RNE, 1'b1, 64'h0000_4000_0000_BC00, 5'b00000, 1'b1);
      finish_ok();

      // Reset while holding a result in DONE
      out_ready_i = 1'b0;
      run_txn(OPS_A, 4'b1111, fpnew_pkg::RNE, 1'b1, 64'h0, 5'b0, 1'b0);
      #2 rst_i = 1'b1;
      #1;
      chk("rst_done_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_done_result", result_o, 64'd0);
      chk("rst_done_status", 64'(status_o), 64'd0);
      chk("rst_done_tag", 64'(tag_o), 64'd0);
      chk("rst_done_busy", 64'(busy_o), 64'd0);
      tick();
      rst_i       = 1'b0;
      out_ready_i = 1'b1;
      seen = 0;
      repeat (8) begin
         tick();
         if (out_valid_o) seen++;
      end
      chk("rst_no_output", 64'(seen), 64'd0);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

`default_nettype wire
